// File: rtl/score_event_scheduler.sv
// Per-lane hit/miss/tail event counters, arbitrated round-robin into a valid/ready score update
// stream (one edge from capture to offer, one update per cycle); combo/multiplier under `SCORE_COMBO_EN.
module score_event_scheduler #(
  parameter int PEND_W = 2,
  parameter int TAIL_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] lane_hits,
  input  logic [3:0] notes_missed,
  input  logic [3:0] tail_ticks,
  input  logic       flush,
  input  logic       upd_ready,
  output logic       upd_valid,
  output logic       upd_sub,
  output logic [7:0] upd_amount,
  output logic [9:0] combo,
  output logic [2:0] multiplier,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
  typedef enum logic [1:0] {CLS_HIT, CLS_MISS, CLS_TAIL} cls_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [TAIL_W-1:0] TAIL_MAX = '1;

  state_t            r_state;
  cls_t              r_cls;
  logic              r_valid;
  logic [7:0]        r_amount;
  logic [1:0]        r_rr_ptr;
  logic              r_ovf;
  logic [PEND_W-1:0] r_hit_cnt  [4];
  logic [PEND_W-1:0] r_miss_cnt [4];
  logic [TAIL_W-1:0] r_tail_cnt [4];

  logic       w_hs;
  logic       w_clr;
  logic       w_take;
  logic [3:0] w_lane_nz;
  logic       w_sel_vld;
  logic [1:0] w_sel_lane;
  cls_t       w_sel_cls;
  logic [7:0] w_sel_amt;
  logic [7:0] w_hit_amt;
  logic [2:0] w_mult_nxt;
  logic [3:0] w_deq_hit;
  logic [3:0] w_deq_miss;
  logic [3:0] w_deq_tail;
  logic       w_drop;

  assign w_hs  = r_valid & upd_ready;
  assign w_clr = flush | (r_state == FLUSH);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_lane_nz[i] = (|r_hit_cnt[i]) | (|r_miss_cnt[i]) | (|r_tail_cnt[i]);
    end
  end

  // Walk from the farthest offset down so the nearest nonzero lane after the pointer wins.
  always_comb begin
    logic [1:0] v_lane;
    v_lane     = r_rr_ptr;
    w_sel_vld  = 1'b0;
    w_sel_lane = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      v_lane = r_rr_ptr + 2'(k);
      if (w_lane_nz[v_lane]) begin
        w_sel_vld  = 1'b1;
        w_sel_lane = v_lane;
      end
    end
  end

  always_comb begin
    w_sel_cls = CLS_TAIL;
    if (|r_hit_cnt[w_sel_lane]) begin
      w_sel_cls = CLS_HIT;
    end else if (|r_miss_cnt[w_sel_lane]) begin
      w_sel_cls = CLS_MISS;
    end
  end

  assign w_take = !w_clr && w_sel_vld &&
                  ((r_state == IDLE) || ((r_state == ISSUE) && w_hs));

`ifdef SCORE_COMBO_EN
  logic [9:0] r_combo;
  logic [2:0] r_mult;
  logic [9:0] w_combo_nxt;

  always_comb begin
    w_combo_nxt = r_combo;
    if (w_hs) begin
      if (r_cls == CLS_HIT) begin
        if (r_combo != 10'd999) w_combo_nxt = r_combo + 10'd1;
      end else if (r_cls == CLS_MISS) begin
        w_combo_nxt = '0;
      end
    end
  end

  // The multiplier follows the combo as it stands after this edge's handshake.
  always_comb begin
    if (w_combo_nxt >= 10'd30)      w_mult_nxt = 3'd4;
    else if (w_combo_nxt >= 10'd20) w_mult_nxt = 3'd3;
    else if (w_combo_nxt >= 10'd10) w_mult_nxt = 3'd2;
    else                            w_mult_nxt = 3'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_combo <= '0;
      r_mult  <= 3'd1;
    end else if (w_clr) begin
      r_combo <= '0;
      r_mult  <= 3'd1;
    end else begin
      r_combo <= w_combo_nxt;
      r_mult  <= w_mult_nxt;
    end
  end

  assign combo      = r_combo;
  assign multiplier = r_mult;
`else
  assign w_mult_nxt = 3'd1;
  assign combo      = '0;
  assign multiplier = 3'd1;
`endif

  assign w_hit_amt = 8'(w_mult_nxt) * 8'd10;

  always_comb begin
    case (w_sel_cls)
      CLS_HIT:  w_sel_amt = w_hit_amt;
      CLS_MISS: w_sel_amt = 8'd1;
      default:  w_sel_amt = 8'(r_tail_cnt[w_sel_lane]);
    endcase
  end

  always_comb begin
    w_deq_hit  = '0;
    w_deq_miss = '0;
    w_deq_tail = '0;
    if (w_take) begin
      case (w_sel_cls)
        CLS_HIT:  w_deq_hit[w_sel_lane]  = 1'b1;
        CLS_MISS: w_deq_miss[w_sel_lane] = 1'b1;
        default:  w_deq_tail[w_sel_lane] = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lane_hits[i] && !w_deq_hit[i] && (r_hit_cnt[i] == PEND_MAX))     w_drop = 1'b1;
      if (notes_missed[i] && !w_deq_miss[i] && (r_miss_cnt[i] == PEND_MAX)) w_drop = 1'b1;
      if (tail_ticks[i] && !w_deq_tail[i] && (r_tail_cnt[i] == TAIL_MAX))  w_drop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_hit_cnt[i]  <= '0;
        r_miss_cnt[i] <= '0;
        r_tail_cnt[i] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_clr) begin
      for (int i = 0; i < 4; i++) begin
        r_hit_cnt[i]  <= '0;
        r_miss_cnt[i] <= '0;
        r_tail_cnt[i] <= '0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_hits[i] && !w_deq_hit[i]) begin
          if (r_hit_cnt[i] != PEND_MAX) r_hit_cnt[i] <= r_hit_cnt[i] + 1'b1;
        end else if (!lane_hits[i] && w_deq_hit[i]) begin
          r_hit_cnt[i] <= r_hit_cnt[i] - 1'b1;
        end

        if (notes_missed[i] && !w_deq_miss[i]) begin
          if (r_miss_cnt[i] != PEND_MAX) r_miss_cnt[i] <= r_miss_cnt[i] + 1'b1;
        end else if (!notes_missed[i] && w_deq_miss[i]) begin
          r_miss_cnt[i] <= r_miss_cnt[i] - 1'b1;
        end

        // A tick landing on the draining edge was not part of the latched amount, so keep it.
        if (w_deq_tail[i]) begin
          r_tail_cnt[i] <= tail_ticks[i] ? TAIL_W'(1) : '0;
        end else if (tail_ticks[i] && (r_tail_cnt[i] != TAIL_MAX)) begin
          r_tail_cnt[i] <= r_tail_cnt[i] + 1'b1;
        end
      end
      r_ovf <= r_ovf | w_drop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_cls    <= CLS_HIT;
      r_amount <= '0;
      r_rr_ptr <= 2'd0;
    end else if (w_clr) begin
      r_state  <= flush ? FLUSH : IDLE;
      r_valid  <= 1'b0;
      r_cls    <= CLS_HIT;
      r_amount <= '0;
    end else begin
      case (r_state)
        IDLE, ISSUE: begin
          if (w_take) begin
            r_state  <= ISSUE;
            r_valid  <= 1'b1;
            r_cls    <= w_sel_cls;
            r_amount <= w_sel_amt;
            r_rr_ptr <= w_sel_lane + 2'd1;
          end else if ((r_state == ISSUE) && w_hs) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign upd_valid  = r_valid;
  assign upd_sub    = (r_cls == CLS_MISS);
  assign upd_amount = r_amount;
  assign overflow   = r_ovf;

endmodule
